// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the boot-time program loader.
//   state_t       loader FSM state encoding
//   HDR_BYTE_DEF  default frame start marker
//   CNT_W         width of the payload byte counter (holds 1..256)
//   len_to_count  maps the LEN byte to a payload count (0 means 256)
package prog_loader_pkg;

    localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
    localparam int unsigned CNT_W        = 9;

    typedef enum logic [3:0] {
        HDR,
        LEN,
        BASE,
        DATA,
        CSUM,
        WAITGO,
        RUN,
        EXEC,
        ERR
    } state_t;

    function automatic logic [CNT_W-1:0] len_to_count(input logic [7:0] len);
        return (len == 8'h00) ? CNT_W'(256) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream handshake plus RAM write port of the loader.
//   in_valid/in_data/in_ready   valid/ready byte stream into the loader
//   ram_addr/ram_data/ram_wren  one-byte-per-cycle RAM write port
// Modports: master = stream source / RAM side, slave = the loader.
interface prog_loader_if #(
    parameter int unsigned AW = 8
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_wren;

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_addr, ram_data, ram_wren
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/prog_loader_csum.sv
// prog_loader_csum: 8-bit modular checksum accumulator.
//   clk, rst  clock, synchronous active-high reset
//   clr       clear the running sum
//   add       add din to the running sum
//   din       byte to add / byte to test against
//   zero      high when (sum + din) mod 256 == 0
module prog_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       zero
);
    logic [7:0] sum;
    logic [7:0] sum_nxt;

    assign sum_nxt = sum + din;
    assign zero    = (sum_nxt == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum_nxt;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader; receives a framed byte stream
// (HDR_BYTE, LEN, BASE, payload, CSUM) and writes the payload into the
// cpu RAM, holding the cpu in reset until a good checksum is seen.
//   clk, rst  clock, synchronous active-high reset
//   load_req  re-enter loading (from EXEC/ERR) or abort a frame in progress
//   go        manual start from WAITGO (ignored in the autorun build)
//   bus       stream handshake and RAM write port (slave modport)
//   cpu_hold  cpu reset; low only in RUN and EXEC
//   cpu_run   one-cycle run pulse, the cycle after RUN
//   done      valid image loaded (WAITGO or EXEC)
//   err       checksum failure, held until load_req or rst
// Build option: define PROG_LOADER_AUTORUN_EN to start the cpu directly
// after a good checksum instead of waiting for go.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic          go,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          cpu_run,
    output logic          done,
    output logic          err
);
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    ptr;
    logic             xfer;
    logic             take;
    logic             data_take;
    logic             csum_zero;

    assign xfer      = bus.in_valid && bus.in_ready;
    // load_req outranks a same-cycle transfer: the byte is dropped.
    assign take      = xfer && !load_req;
    assign data_take = take && (state == DATA);

    prog_loader_csum u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (take && (state == BASE)),
        .add  (data_take),
        .din  (bus.in_data),
        .zero (csum_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_req && (state inside {HDR, LEN, BASE, DATA, CSUM, EXEC, ERR})) begin
            state_nxt = HDR;
        end else begin
            unique case (state)
                HDR:    if (xfer && (bus.in_data == HDR_BYTE)) state_nxt = LEN;
                LEN:    if (xfer) state_nxt = BASE;
                BASE:   if (xfer) state_nxt = DATA;
                DATA:   if (xfer && (count == CNT_W'(1))) state_nxt = CSUM;
                CSUM: begin
                    if (xfer) begin
                        if (csum_zero) begin
`ifdef PROG_LOADER_AUTORUN_EN
                            state_nxt = RUN;
`else
                            state_nxt = WAITGO;
`endif
                        end else begin
                            state_nxt = ERR;
                        end
                    end
                end
                WAITGO: begin
`ifndef PROG_LOADER_AUTORUN_EN
                    if (go) state_nxt = RUN;
`endif
                end
                RUN:     state_nxt = EXEC;
                EXEC:    state_nxt = EXEC;
                ERR:     state_nxt = ERR;
                default: state_nxt = HDR;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state inside {HDR, LEN, BASE, DATA, CSUM});
        cpu_hold     = !(state inside {RUN, EXEC});
        done         = (state inside {WAITGO, EXEC});
        err          = (state == ERR);
    end

    // Write port and run pulse are registered: a DATA byte is written the
    // cycle after it is accepted, and cpu_run follows RUN by one cycle so
    // the cpu is already out of reset when it sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            ptr          <= '0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
            bus.ram_wren <= 1'b0;
            cpu_run      <= 1'b0;
        end else begin
            bus.ram_wren <= data_take;
            cpu_run      <= (state == RUN);
            if (take) begin
                unique case (state)
                    LEN:  count <= len_to_count(bus.in_data);
                    BASE: ptr   <= AW'(bus.in_data);
                    DATA: begin
                        bus.ram_addr <= ptr;
                        bus.ram_data <= bus.in_data;
                        ptr          <= ptr + 1'b1;
                        count        <= count - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       go_in;
        logic       rdy;
        logic       wren;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       hold;
        logic       run;
        logic       dn;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_req = 1'b0;
    logic go = 1'b0;
    logic cpu_hold, cpu_run, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int run_cnt = 0;

    prog_loader_if #(.AW(8)) bus ();

    prog_loader #(.HDR_BYTE(8'hA5), .AW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .go       (go),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .cpu_run  (cpu_run),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ram_wren) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_data);
        end
        if (cpu_run) run_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        run_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit bp);
        bit sent = 1'b0;
        bus.in_data = b;
        for (int i = 0; i < 64 && !sent; i++) begin
            bus.in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.in_valid && bus.in_ready) sent = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        if (!sent) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %02h not accepted in 64 cycles", b);
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$], input bit bp);
        foreach (q[i]) send(q[i], bp);
    endtask

    // Called on the first cycle after a good checksum byte was accepted.
    task automatic expect_start(input string tag);
`ifndef PROG_LOADER_AUTORUN_EN
        int bad = 0;
        chk({tag, "_wait_done"}, done, 1);
        chk({tag, "_wait_hold"}, cpu_hold, 1);
        for (int i = 0; i < 20; i++) begin
            go = 1'b0;
            step();
            if (cpu_run || !done || !cpu_hold) bad++;
        end
        chk({tag, "_nogo_quiet"}, bad, 0);
        go = 1'b1;
        step();
        go = 1'b0;
`endif
        chk({tag, "_run_hold"}, cpu_hold, 0);
        chk({tag, "_run_norun"}, cpu_run, 0);
        step();
        chk({tag, "_exec_run"}, cpu_run, 1);
        chk({tag, "_exec_done"}, done, 1);
        chk({tag, "_exec_hold"}, cpu_hold, 0);
        step();
        chk({tag, "_exec_run_end"}, cpu_run, 0);
    endtask

    task automatic reenter(input string tag);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk({tag, "_reent_hold"}, cpu_hold, 1);
        chk({tag, "_reent_done"}, done, 0);
        chk({tag, "_reent_ready"}, bus.in_ready, 1);
    endtask

    vec_t tbl[12];
    logic [7:0] q[$];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Basic load: payload AA,BB,CC sums to 0x31, so the checksum is 0xCF.
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 8'h10, 8'hAA, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 8'h11, 8'hBB, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'hCF, 1'b0, 1'b1, 1'b1, 8'h12, 8'hCC, 1'b1, 1'b0, 1'b0};
`ifdef PROG_LOADER_AUTORUN_EN
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
`else
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
`endif

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_data", bus.ram_data, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_run", cpu_run, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Basic load, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = tbl[i].vld;
            bus.in_data  = tbl[i].dat;
            go           = tbl[i].go_in;
            chk($sformatf("tbl%0d_ready", i), bus.in_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_wren", i), bus.ram_wren, tbl[i].wren);
            if (tbl[i].wren) begin
                chk($sformatf("tbl%0d_addr", i), bus.ram_addr, tbl[i].addr);
                chk($sformatf("tbl%0d_wdata", i), bus.ram_data, tbl[i].wdata);
            end
            chk($sformatf("tbl%0d_hold", i), cpu_hold, tbl[i].hold);
            chk($sformatf("tbl%0d_run", i), cpu_run, tbl[i].run);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_err", i), err, 0);
            step();
        end
        bus.in_valid = 1'b0;
        go = 1'b0;
        reenter("basic");

        // Bad checksum: sum 0x03 + 0x00 is not zero
        clear_log();
        q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00};
        send_seq(q, 1'b0);
        chk("bad_err", err, 1);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_ready", bus.in_ready, 0);
        chk("bad_done", done, 0);
        repeat (3) step();
        chk("bad_err_sticky", err, 1);
        chk("bad_run_cnt", run_cnt, 0);
        chk("bad_wr_cnt", wr_addr.size(), 2);
        chk("bad_wr1_addr", wr_addr[1], 8'h01);
        chk("bad_wr1_data", wr_data[1], 8'h02);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("bad_clr_err", err, 0);
        chk("bad_clr_ready", bus.in_ready, 1);

        // Length 0 (256 bytes) with address wrap; bytes 0..255 sum to 0x80
        clear_log();
        q = '{8'hA5, 8'h00, 8'hFE};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        q.push_back(8'h80);
        send_seq(q, 1'b0);
        expect_start("wrap");
        chk("wrap_wr_cnt", wr_addr.size(), 256);
        chk("wrap_first_addr", wr_addr[0], 8'hFE);
        chk("wrap_third_addr", wr_addr[2], 8'h00);
        chk("wrap_third_data", wr_data[2], 8'h02);
        chk("wrap_last_addr", wr_addr[255], 8'hFD);
        chk("wrap_last_data", wr_data[255], 8'hFF);
        reenter("wrap");

        // Resync junk then a frame under random backpressure; 11+22 -> CD
        clear_log();
        q = '{8'h00, 8'h13, 8'hA5, 8'h02, 8'h20, 8'h11, 8'h22, 8'hCD};
        send_seq(q, 1'b1);
        expect_start("resync");
        chk("resync_wr_cnt", wr_addr.size(), 2);
        chk("resync_wr0_addr", wr_addr[0], 8'h20);
        chk("resync_wr0_data", wr_data[0], 8'h11);
        chk("resync_wr1_addr", wr_addr[1], 8'h21);
        chk("resync_wr1_data", wr_data[1], 8'h22);
        reenter("resync");

        // Abort after 2 of 4 data bytes; the same-cycle byte is dropped
        clear_log();
        q = '{8'hA5, 8'h04, 8'h40, 8'h01, 8'h02};
        send_seq(q, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h03;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_ready", bus.in_ready, 1);
        chk("abort_wren", bus.ram_wren, 0);
        step();
        chk("abort_wr_cnt", wr_addr.size(), 2);
        chk("abort_hold", cpu_hold, 1);
        // A fresh frame must now parse from HDR; 55+AB = 0x100
        clear_log();
        q = '{8'hA5, 8'h01, 8'h60, 8'h55, 8'hAB};
        send_seq(q, 1'b0);
        expect_start("after_abort");
        chk("after_abort_wr_addr", wr_addr[0], 8'h60);
        reenter("after_abort");

        // rst mid-frame cancels the pending write of the byte it collides with
        clear_log();
        q = '{8'hA5, 8'h03, 8'h50, 8'h07};
        send_seq(q, 1'b0);
        chk("rstmid_pending_wren", bus.ram_wren, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h08;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rstmid_wren", bus.ram_wren, 0);
        chk("rstmid_addr", bus.ram_addr, 0);
        chk("rstmid_data", bus.ram_data, 0);
        chk("rstmid_ready", bus.in_ready, 1);
        chk("rstmid_hold", cpu_hold, 1);
        chk("rstmid_done", done, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_run", cpu_run, 0);
        step();
        chk("rstmid_wr_cnt", wr_addr.size(), 1);
        chk("rstmid_wren_after", bus.ram_wren, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
